parity_enc_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 7-bit parity encoder between N_REQ requesters. Each requester offers a 7-bit word plus a parity-mode bit. The block grants one requester per cycle, encodes the word to an 8-bit codeword, and holds it in a registered valid/ready output stage. It sits between upstream word producers and the serial/link stage that consumes 8-bit codewords.

---
 rtl/parity_enc_pkg.sv | 7 +
 rtl/parity_encoder_7b.sv | 15 +
 rtl/parity_enc_arbiter.sv | 113 +++++++++++
 tb/tb_parity_enc_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/parity_enc_pkg.sv
// Shared widths and parity-mode encodings for the parity encoder arbiter.
package parity_enc_pkg;
   localparam int WORD_W = 7;
   localparam int CODE_W = 8;
   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/parity_encoder_7b.sv
// Combinational 7-bit parity encoder: codeword is {word, parity}, parity in bit 0.
module parity_encoder_7b
   import parity_enc_pkg::*;
(
   input  logic [WORD_W-1:0] data_in,
   input  logic              control,
   output logic [CODE_W-1:0] data_out
);

   logic parity;

   assign parity   = (control == PAR_ODD) ? ~^data_in : ^data_in;
   assign data_out = {data_in, parity};

endmodule

// File: rtl/parity_enc_arbiter.sv
// Round-robin arbiter sharing one parity encoder between N_REQ requesters,
// feeding a single registered valid/ready output stage.
module parity_enc_arbiter
   import parity_enc_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [WORD_W*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]        req_odd,
   output logic [N_REQ-1:0]        req_ready,
   output logic                    out_valid,
   output logic [CODE_W-1:0]       out_data,
   output logic [ID_W-1:0]         out_src,
   input  logic                    out_ready,
   output logic [CNT_W-1:0]        words_sent
);

   logic              out_valid_q;
   logic [CODE_W-1:0] out_data_q;
   logic [ID_W-1:0]   out_src_q;
   logic [ID_W-1:0]   ptr_q;
   logic [ID_W-1:0]   ptr_d;
   logic [CNT_W-1:0]  words_q;

   logic              load_ok;
   logic [N_REQ-1:0]  grant_vec;
   logic [ID_W-1:0]   grant_idx;
   logic              grant_any;
   logic [ID_W:0]     scan_sum;
   logic [ID_W-1:0]   scan_idx;
   logic [WORD_W-1:0] mux_word;
   logic              mux_odd;
   logic [CODE_W-1:0] enc_code;

   // The output register can take a new codeword when empty or draining this cycle.
   assign load_ok = !out_valid_q || out_ready;

   always_comb begin
      grant_vec = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      scan_sum  = '0;
      scan_idx  = '0;
      if (rst_n && load_ok) begin
         for (int k = 0; k < N_REQ; k++) begin
            scan_sum = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_REQ)) begin
               scan_sum = scan_sum - (ID_W+1)'(N_REQ);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (!grant_any && req_valid[scan_idx]) begin
               grant_any           = 1'b1;
               grant_idx           = scan_idx;
               grant_vec[scan_idx] = 1'b1;
            end
         end
      end
   end

   // Data mux is driven only by the one-hot grant, so req_data never reaches req_ready.
   always_comb begin
      mux_word = '0;
      mux_odd  = PAR_EVEN;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_vec[i]) begin
            mux_word = req_data[WORD_W*i +: WORD_W];
            mux_odd  = req_odd[i];
         end
      end
   end

   parity_encoder_7b u_enc (
      .data_in  (mux_word),
      .control  (mux_odd),
      .data_out (enc_code)
   );

   assign ptr_d = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + ID_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         ptr_q       <= '0;
         words_q     <= '0;
      end else begin
         if (grant_any) begin
            out_valid_q <= 1'b1;
            out_data_q  <= enc_code;
            out_src_q   <= grant_idx;
            ptr_q       <= ptr_d;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (out_valid_q && out_ready && (words_q != {CNT_W{1'b1}})) begin
            words_q <= words_q + CNT_W'(1);
         end
      end
   end

   assign req_ready  = grant_vec;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_src    = out_src_q;
   assign words_sent = words_q;

endmodule

// File: tb/tb_parity_enc_arbiter.sv
// Directed bench for parity_enc_arbiter: vector table plus multi-cycle sequences.
module tb_parity_enc_arbiter;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;

   // Fixed requester words; encodings worked out by hand below.
   localparam logic [6:0] D0 = 7'b1010101; // even 0xAA, odd 0xAB
   localparam logic [6:0] D1 = 7'b0000001; // even 0x03, odd 0x02
   localparam logic [6:0] D2 = 7'b0000000; // even 0x00, odd 0x01
   localparam logic [6:0] D3 = 7'b1111111; // even 0xFF, odd 0xFE

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [N_REQ-1:0]  req_valid;
   logic [7*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]  req_odd;
   logic              out_ready;

   logic [N_REQ-1:0]  req_ready;
   logic              out_valid;
   logic [7:0]        out_data;
   logic [ID_W-1:0]   out_src;
   logic [15:0]       words_sent;

   logic [N_REQ-1:0]  sat_req_ready;
   logic              sat_out_valid;
   logic [7:0]        sat_out_data;
   logic [ID_W-1:0]   sat_out_src;
   logic [3:0]        sat_words_sent;

   parity_enc_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_odd    (req_odd),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_src    (out_src),
      .out_ready  (out_ready),
      .words_sent (words_sent)
   );

   parity_enc_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(4)) u_sat (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_odd    (req_odd),
      .req_ready  (sat_req_ready),
      .out_valid  (sat_out_valid),
      .out_data   (sat_out_data),
      .out_src    (sat_out_src),
      .out_ready  (out_ready),
      .words_sent (sat_words_sent)
   );

   typedef struct {
      logic [3:0]  valid;
      logic [3:0]  odd;
      logic        ordy;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [7:0]  exp_od;
      logic [1:0]  exp_src;
      logic [15:0] exp_ws;
   } vec_t;

   vec_t vecs[13];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      req_odd   = '0;
      out_ready = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      req_data  = {D3, D2, D1, D0};
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_odd   = '0;
      out_ready = 1'b1;
      repeat (2) tick();
      chk("reset_ready",  32'(req_ready),  32'h0);
      chk("reset_valid",  32'(out_valid),  32'h0);
      chk("reset_data",   32'(out_data),   32'h0);
      chk("reset_src",    32'(out_src),    32'h0);
      chk("reset_words",  32'(words_sent), 32'h0);
      req_valid = '0;
      rst_n     = 1'b1;

      //            valid    odd      rdy  exp_rdy  ov    od     src   ws
      vecs[0]  = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'hAA, 2'd0, 16'd0};
      vecs[1]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hAA, 2'd0, 16'd1};
      vecs[2]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h01, 2'd2, 16'd1};
      vecs[3]  = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'h01, 2'd2, 16'd1};
      vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 8'hFF, 2'd3, 16'd2};
      vecs[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'hAB, 2'd0, 16'd3};
      vecs[6]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 8'hFF, 2'd3, 16'd4};
      vecs[7]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h02, 2'd1, 16'd5};
      vecs[8]  = '{4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b1, 8'hAA, 2'd0, 16'd6};
      vecs[9]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 8'hAA, 2'd0, 16'd6};
      vecs[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'hAA, 2'd0, 16'd7};
      vecs[11] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'hAA, 2'd0, 16'd7};
      vecs[12] = '{4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h03, 2'd1, 16'd7};

      for (int i = 0; i < 13; i++) begin
         req_valid = vecs[i].valid;
         req_odd   = vecs[i].odd;
         out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_rdy));
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(out_valid),  32'(vecs[i].exp_ov));
         chk($sformatf("vec%0d_data", i),  32'(out_data),   32'(vecs[i].exp_od));
         chk($sformatf("vec%0d_src", i),   32'(out_src),    32'(vecs[i].exp_src));
         chk($sformatf("vec%0d_words", i), 32'(words_sent), 32'(vecs[i].exp_ws));
      end

      // Round-robin with every requester valid and no backpressure.
      do_reset();
      req_valid = 4'b1111;
      req_odd   = 4'b0000;
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
         tick();
         chk($sformatf("rr%0d_src", k),   32'(out_src),   32'(k % 4));
         chk($sformatf("rr%0d_valid", k), 32'(out_valid), 32'h1);
      end
      req_valid = '0;
      #1;
      chk("rr_idle_ready", 32'(req_ready), 32'h0);
      tick();
      chk("rr_words",      32'(words_sent), 32'd6);
      chk("rr_drain_valid", 32'(out_valid), 32'h0);

      // Backpressure: held codeword must not move, no grant until drained.
      do_reset();
      req_valid = 4'b0100;
      #1;
      chk("bp_first_ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp%0d_ready", k), 32'(req_ready), 32'h0);
         tick();
         chk($sformatf("bp%0d_data", k),  32'(out_data),  32'h00);
         chk($sformatf("bp%0d_src", k),   32'(out_src),   32'd2);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", 32'(req_ready), 32'b1000);
      tick();
      chk("bp_release_words", 32'(words_sent), 32'd1);
      chk("bp_release_src",   32'(out_src),    32'd3);
      chk("bp_release_data",  32'(out_data),   32'hFF);

      // Asynchronous reset in the middle of a held transfer.
      req_valid = 4'b0001;
      req_odd   = 4'b0001;
      #1;
      chk("mr_ready", 32'(req_ready), 32'b0001);
      tick();
      chk("mr_loaded", 32'(out_data),   32'hAB);
      chk("mr_words",  32'(words_sent), 32'd2);
      out_ready = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("mr_rst_valid", 32'(out_valid),  32'h0);
      chk("mr_rst_data",  32'(out_data),   32'h0);
      chk("mr_rst_src",   32'(out_src),    32'h0);
      chk("mr_rst_words", 32'(words_sent), 32'h0);
      chk("mr_rst_ready", 32'(req_ready),  32'h0);
      tick();
      rst_n     = 1'b1;
      req_valid = 4'b1111;
      req_odd   = 4'b0000;
      out_ready = 1'b1;
      #1;
      chk("mr_first_grant", 32'(req_ready), 32'b0001);

      // Counter saturation on the CNT_W=4 instance against the 16-bit one.
      do_reset();
      req_valid = 4'b1111;
      out_ready = 1'b1;
      repeat (16) tick();
      chk("sat15_main", 32'(words_sent),     32'd15);
      chk("sat15_sat",  32'(sat_words_sent), 32'd15);
      tick();
      chk("sat16_main", 32'(words_sent),     32'd16);
      chk("sat16_sat",  32'(sat_words_sent), 32'd15);
      repeat (3) tick();
      req_valid = '0;
      tick();
      chk("sat20_main", 32'(words_sent),     32'd20);
      chk("sat20_sat",  32'(sat_words_sent), 32'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
